// File: rtl/avalon_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_arbiter
//
// Two-master to one-slave Avalon-MM arbiter. The instruction master (i_*) and
// the data master (d_*) share a single slave (s_*). Exactly one slave
// transaction is in flight at a time. Contention is resolved round-robin
// against the master that owned the previous transaction.
//
// Each transaction walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
//   IDLE  : arbitrate and latch the winner's request into the s_* registers
//   ISSUE : one cycle with the command presented; the slave's waitrequest is
//           not valid yet, so it is ignored here
//   WAIT  : hold s_* until the slave drops waitrequest, then capture readdata
//   DONE  : the owner sees waitrequest low for one cycle; the slave sees a
//           guaranteed idle cycle
//
// Parameters
//   RESET_LAST_GRANT : master treated as last-granted after reset
//                      (0 = instruction, 1 = data)
//
// Ports
//   clk, reset                       : clock, synchronous active-high reset
//   i_address/byteenable/read/write/writedata : instruction-master request
//   i_waitrequest, i_readdata        : instruction-master response
//   d_address/byteenable/read/write/writedata : data-master request
//   d_waitrequest, d_readdata        : data-master response
//   s_address/byteenable/read/write/writedata : registered slave request
//   s_waitrequest, s_readdata        : slave response
//   grant                            : owner of current/last transaction
//   busy                             : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module avalon_arbiter #(
    parameter bit RESET_LAST_GRANT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_address,
    input  logic [3:0]  i_byteenable,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    output logic [31:0] s_address,
    output logic [3:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,

    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    // grant_q doubles as last_grant: it names the owner of the current or
    // most recent transaction, which is exactly what round-robin needs.
    logic        grant_q, grant_d;
    logic [31:0] s_address_q, s_address_d;
    logic [3:0]  s_byteenable_q, s_byteenable_d;
    logic        s_read_q, s_read_d;
    logic        s_write_q, s_write_d;
    logic [31:0] s_writedata_q, s_writedata_d;
    logic [31:0] i_readdata_q, i_readdata_d;
    logic [31:0] d_readdata_q, d_readdata_d;

    logic i_req;
    logic d_req;
    logic sel;      // arbitration winner in IDLE: 0 = instruction, 1 = data

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        s_address_d    = s_address_q;
        s_byteenable_d = s_byteenable_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        s_writedata_d  = s_writedata_q;
        i_readdata_d   = i_readdata_q;
        d_readdata_d   = d_readdata_q;
        sel            = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // Contention goes to whichever master did not own the
                    // previous transaction.
                    sel            = (i_req && d_req) ? ~grant_q : d_req;
                    grant_d        = sel;
                    s_address_d    = sel ? d_address    : i_address;
                    s_byteenable_d = sel ? d_byteenable : i_byteenable;
                    s_writedata_d  = sel ? d_writedata  : i_writedata;
                    // read wins when a master raises both strobes
                    s_read_d       = sel ? d_read : i_read;
                    s_write_d      = sel ? (d_write & ~d_read) : (i_write & ~i_read);
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!s_waitrequest) begin
                    if (s_read_q) begin
                        if (grant_q) d_readdata_d = s_readdata;
                        else         i_readdata_d = s_readdata;
                    end
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= RESET_LAST_GRANT;
            s_address_q    <= 32'd0;
            s_byteenable_q <= 4'd0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            s_writedata_q  <= 32'd0;
            i_readdata_q   <= 32'd0;
            d_readdata_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            s_address_q    <= s_address_d;
            s_byteenable_q <= s_byteenable_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            s_writedata_q  <= s_writedata_d;
            i_readdata_q   <= i_readdata_d;
            d_readdata_q   <= d_readdata_d;
        end
    end

    // A master is stalled while it requests, except during its own DONE cycle.
    assign i_waitrequest = i_req && !((state_q == DONE) && (grant_q == 1'b0));
    assign d_waitrequest = d_req && !((state_q == DONE) && (grant_q == 1'b1));

    assign s_address    = s_address_q;
    assign s_byteenable = s_byteenable_q;
    assign s_read       = s_read_q;
    assign s_write      = s_write_q;
    assign s_writedata  = s_writedata_q;
    assign i_readdata   = i_readdata_q;
    assign d_readdata   = d_readdata_q;
    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_avalon_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_arbiter
//
// Directed bench for avalon_arbiter. A small word-addressed slave memory with a
// programmable number of waitrequest cycles answers the shared port. Each
// scenario task drives its vectors cycle by cycle and checks hand-computed
// expectations one cycle at a time. Inputs change 1 ns after a rising edge and
// outputs are sampled there too, well away from the edge.
// -----------------------------------------------------------------------------
module tb_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] i_address = '0;
    logic [3:0]  i_byteenable = '0;
    logic        i_read = 1'b0;
    logic        i_write = 1'b0;
    logic [31:0] i_writedata = '0;
    logic        i_waitrequest;
    logic [31:0] i_readdata;

    logic [31:0] d_address = '0;
    logic [3:0]  d_byteenable = '0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_writedata = '0;
    logic        d_waitrequest;
    logic [31:0] d_readdata;

    logic [31:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    logic        grant;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_arbiter #(.RESET_LAST_GRANT(1'b0)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_address     (i_address),
        .i_byteenable  (i_byteenable),
        .i_read        (i_read),
        .i_write       (i_write),
        .i_writedata   (i_writedata),
        .i_waitrequest (i_waitrequest),
        .i_readdata    (i_readdata),
        .d_address     (d_address),
        .d_byteenable  (d_byteenable),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .s_address     (s_address),
        .s_byteenable  (s_byteenable),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_waitrequest (s_waitrequest),
        .s_readdata    (s_readdata),
        .grant         (grant),
        .busy          (busy)
    );

    // ---------------- slave model ----------------
    // The memory reloads its preset contents whenever reset is high.
    logic [31:0] mem [0:15];
    int          act_cnt;        // cycles the current slave command has been active
    int          wait_cycles = 0;

    function automatic logic [31:0] init_word(input int k);
        case (k)
            1:       return 32'h0BAD_F00D;
            3:       return 32'hDEAD_BEEF;
            4:       return 32'h1111_2222;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // The first active cycle (ISSUE) always reports waitrequest, as a slave
    // that raises it one cycle late would; afterwards wait_cycles more cycles.
    assign s_waitrequest = (s_read | s_write) && (act_cnt <= wait_cycles);
    assign s_readdata    = mem[s_address[5:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
            act_cnt <= 0;
        end else begin
            if (s_read | s_write) act_cnt <= act_cnt + 1;
            else                  act_cnt <= 0;
            if (s_write && !s_waitrequest) begin
                for (int b = 0; b < 4; b++)
                    if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b exp=0", busy); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got=%b exp=0", grant); end
        checks++; if ({s_read, s_write} !== 2'b00) begin errors++; $display("FAIL reset_rw: got=%b exp=00", {s_read, s_write}); end
        checks++; if (s_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got=%h exp=0", s_address); end
        checks++; if (s_byteenable !== 4'd0 || s_writedata !== 32'd0) begin errors++; $display("FAIL reset_be_wd: got=%h/%h exp=0/0", s_byteenable, s_writedata); end
        checks++; if (i_readdata !== 32'd0 || d_readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got=%h/%h exp=0/0", i_readdata, d_readdata); end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        d_address = 32'h0000_000C; d_byteenable = 4'hF; d_read = 1'b1;
        #1;
        checks++; if (d_waitrequest !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sr_c0: wr=%b busy=%b exp 1/0", d_waitrequest, busy); end
        tick(); // cycle 1 ISSUE
        checks++; if (s_read !== 1'b1 || s_address !== 32'h0C || grant !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL sr_issue: rd=%b addr=%h gnt=%b busy=%b exp 1/0c/1/1", s_read, s_address, grant, busy); end
        tick(); // cycle 2 WAIT
        checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL sr_c2_wr: got=%b exp=1", d_waitrequest); end
        tick(); // cycle 3 DONE
        checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_c3_wr: got=%b exp=0", d_waitrequest); end
        checks++; if (d_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rdata: got=%h exp=deadbeef", d_readdata); end
        checks++; if (i_readdata !== 32'd0) begin errors++; $display("FAIL sr_i_hold: got=%h exp=0", i_readdata); end
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL sr_done_rd: got=%b exp=0", s_read); end
        d_read = 1'b0;
        tick();
        $display("test_single_read done: d_readdata=%h", d_readdata);
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_address = 32'h04; i_byteenable = 4'hF; i_read = 1'b1;
        d_address = 32'h08; d_byteenable = 4'hF; d_writedata = 32'h1234_5678; d_write = 1'b1;
        #1;
        tick(); // ISSUE for data write
        checks++; if (grant !== 1'b1 || s_write !== 1'b1 || s_read !== 1'b0 || s_writedata !== 32'h1234_5678) begin errors++; $display("FAIL sim_first: gnt=%b wr=%b rd=%b wd=%h exp 1/1/0/12345678", grant, s_write, s_read, s_writedata); end
        tick(); // WAIT
        tick(); // DONE
        checks++; if (d_waitrequest !== 1'b0 || i_waitrequest !== 1'b1) begin errors++; $display("FAIL sim_done1: d_wr=%b i_wr=%b exp 0/1", d_waitrequest, i_waitrequest); end
        d_write = 1'b0;
        tick(); // IDLE
        checks++; if (busy !== 1'b0 || i_waitrequest !== 1'b1 || s_read !== 1'b0) begin errors++; $display("FAIL sim_idle: busy=%b i_wr=%b rd=%b exp 0/1/0", busy, i_waitrequest, s_read); end
        tick(); // ISSUE for instruction read
        checks++; if (grant !== 1'b0 || s_read !== 1'b1 || s_address !== 32'h04) begin errors++; $display("FAIL sim_second: gnt=%b rd=%b addr=%h exp 0/1/04", grant, s_read, s_address); end
        tick(); // WAIT
        checks++; if (i_waitrequest !== 1'b1) begin errors++; $display("FAIL sim_iwait: got=%b exp=1", i_waitrequest); end
        tick(); // DONE
        checks++; if (i_waitrequest !== 1'b0 || i_readdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL sim_done2: wr=%b rdata=%h exp 0/0badf00d", i_waitrequest, i_readdata); end
        checks++; if (mem[2] !== 32'h1234_5678 || d_readdata !== 32'd0) begin errors++; $display("FAIL sim_write: mem2=%h d_rdata=%h exp 12345678/0", mem[2], d_readdata); end
        i_read = 1'b0;
        tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_back_to_back();
        logic exp_g;
        do_reset();
        i_address = 32'h04; i_read = 1'b1;
        d_address = 32'h0C; d_read = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0);
            tick(); // ISSUE
            checks++; if (grant !== exp_g || s_read !== 1'b1) begin errors++; $display("FAIL b2b_grant[%0d]: gnt=%b rd=%b exp %b/1", k, grant, s_read, exp_g); end
            tick(); // WAIT
            tick(); // DONE
            checks++; if ({s_read, s_write} !== 2'b00 || (exp_g ? d_waitrequest : i_waitrequest) !== 1'b0 || (exp_g ? i_waitrequest : d_waitrequest) !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: rw=%b i_wr=%b d_wr=%b gnt_exp=%b", k, {s_read, s_write}, i_waitrequest, d_waitrequest, exp_g); end
            tick(); // IDLE gap
            checks++; if ({s_read, s_write} !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d]: rw=%b busy=%b exp 00/0", k, {s_read, s_write}, busy); end
            if (k == 5) clear_inputs();
            $display("b2b transaction %0d grant=%b", k, grant);
        end
        checks++; if (i_readdata !== 32'h0BAD_F00D || d_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rdata: i=%h d=%h exp 0badf00d/deadbeef", i_readdata, d_readdata); end
        tick();
    endtask

    task automatic test_wait_stable();
        wait_cycles = 4;
        d_address = 32'h14; d_writedata = 32'hA5A5_A5A5; d_byteenable = 4'h3; d_write = 1'b1;
        #1;
        tick(); // cycle 1 ISSUE
        checks++; if (s_write !== 1'b1 || s_byteenable !== 4'h3 || grant !== 1'b1) begin errors++; $display("FAIL ws_issue: wr=%b be=%h gnt=%b exp 1/3/1", s_write, s_byteenable, grant); end
        d_address = 32'h20; d_writedata = 32'h0; d_byteenable = 4'hF;
        for (int c = 2; c <= 6; c++) begin
            tick();
            checks++; if (s_address !== 32'h14 || s_writedata !== 32'hA5A5_A5A5 || s_write !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL ws_hold[c%0d]: addr=%h wd=%h wr=%b d_wr=%b exp 14/a5a5a5a5/1/1", c, s_address, s_writedata, s_write, d_waitrequest); end
        end
        tick(); // cycle 7 DONE
        checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL ws_c7: got=%b exp=0", d_waitrequest); end
        checks++; if (mem[5] !== 32'h0000_A5A5) begin errors++; $display("FAIL ws_mem: got=%h exp=0000a5a5", mem[5]); end
        d_write = 1'b0; wait_cycles = 0;
        tick();
        $display("test_wait_stable done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_cycles = 3;
        d_address = 32'h0C; d_byteenable = 4'hF; d_read = 1'b1;
        #1;
        tick(); // ISSUE
        tick(); // WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || s_read !== 1'b0 || d_waitrequest !== 1'b1 || grant !== 1'b0 || d_readdata !== 32'd0) begin errors++; $display("FAIL rm_abort: busy=%b rd=%b d_wr=%b gnt=%b rdata=%h exp 0/0/1/0/0", busy, s_read, d_waitrequest, grant, d_readdata); end
        tick(); // fresh ISSUE
        checks++; if (s_read !== 1'b1 || busy !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL rm_reissue: rd=%b busy=%b gnt=%b exp 1/1/1", s_read, busy, grant); end
        for (int c = 2; c <= 5; c++) tick();
        checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_c5: got=%b exp=1", d_waitrequest); end
        tick(); // cycle 6 DONE
        checks++; if (d_waitrequest !== 1'b0 || d_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rm_done: wr=%b rdata=%h exp 0/deadbeef", d_waitrequest, d_readdata); end
        d_read = 1'b0; wait_cycles = 0;
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_read_write_both();
        d_address = 32'h10; d_byteenable = 4'hF; d_writedata = 32'hFFFF_FFFF;
        d_read = 1'b1; d_write = 1'b1;
        #1;
        tick(); // ISSUE
        checks++; if (s_read !== 1'b1 || s_write !== 1'b0 || s_address !== 32'h10) begin errors++; $display("FAIL rw_issue: rd=%b wr=%b addr=%h exp 1/0/10", s_read, s_write, s_address); end
        tick();
        tick(); // DONE
        checks++; if (d_readdata !== 32'h1111_2222 || mem[4] !== 32'h1111_2222) begin errors++; $display("FAIL rw_result: rdata=%h mem4=%h exp 11112222/11112222", d_readdata, mem[4]); end
        clear_inputs();
        tick();
        $display("test_read_write_both done");
    endtask

    task automatic test_drop_mid();
        i_address = 32'h0C; i_byteenable = 4'hF; i_read = 1'b1;
        #1;
        tick(); // ISSUE
        i_read = 1'b0;
        tick(); // WAIT
        tick(); // DONE
        checks++; if (busy !== 1'b1 || i_waitrequest !== 1'b0 || i_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dm_done: busy=%b wr=%b rdata=%h exp 1/0/deadbeef", busy, i_waitrequest, i_readdata); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dm_idle: busy=%b exp=0", busy); end
        $display("test_drop_mid done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_wait_stable();
        test_reset_mid();
        test_read_write_both();
        test_drop_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
